// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage
// Description : IF/ID pipeline register. Assembles opcode + immediate pairs
//               from a 16-bit fetch stream, with stall and jump flush.
//               Optional macro IFID_BUBBLE_CNT_EN adds a saturating
//               bubble_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage #(
    parameter int                DATA_W   = 16,
    parameter int                PC_W     = 32,
    parameter int                IMM_BIT  = 15,
    parameter logic [DATA_W-1:0] NOP_WORD = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instruction_buf,
    input  logic              fetch_valid,
    input  logic [PC_W-1:0]   fetch_pc,
    input  logic              stall,
    input  logic              jump_occured,
    input  logic              direct_jump,
    output logic              fetch_hold,
    output logic [DATA_W-1:0] id_instr,
    output logic [DATA_W-1:0] id_imm,
    output logic [PC_W-1:0]   id_pc,
    output logic              id_valid,
    output logic              id_two_word
`ifdef IFID_BUBBLE_CNT_EN
    ,
    output logic [15:0]       bubble_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_IMM = 1'b1
    } state_t;

    state_t            state_q,       state_d;
    logic [DATA_W-1:0] id_instr_q,    id_instr_d;
    logic [DATA_W-1:0] id_imm_q,      id_imm_d;
    logic [PC_W-1:0]   id_pc_q,       id_pc_d;
    logic              id_valid_q,    id_valid_d;
    logic              id_two_word_q, id_two_word_d;
    logic [DATA_W-1:0] hold_instr_q,  hold_instr_d;
    logic [PC_W-1:0]   hold_pc_q,     hold_pc_d;
    logic              w_flush;

    assign w_flush    = jump_occured | direct_jump;
    assign fetch_hold = stall & ~w_flush;

    always_comb begin
        state_d       = state_q;
        id_instr_d    = id_instr_q;
        id_imm_d      = id_imm_q;
        id_pc_d       = id_pc_q;
        id_valid_d    = id_valid_q;
        id_two_word_d = id_two_word_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;

        if (w_flush) begin
            state_d       = ST_IDLE;
            id_valid_d    = 1'b0;
            id_instr_d    = NOP_WORD;
            id_two_word_d = 1'b0;
            hold_instr_d  = '0;
            hold_pc_d     = '0;
        end else if (!stall) begin
            // Default for an advancing cycle is a bubble; real words override below.
            id_valid_d    = 1'b0;
            id_instr_d    = NOP_WORD;
            id_two_word_d = 1'b0;
            if (fetch_valid) begin
                case (state_q)
                    ST_IDLE: begin
                        if (instruction_buf[IMM_BIT]) begin
                            hold_instr_d = instruction_buf;
                            hold_pc_d    = fetch_pc;
                            state_d      = ST_WAIT_IMM;
                        end else begin
                            id_instr_d = instruction_buf;
                            id_imm_d   = '0;
                            id_pc_d    = fetch_pc;
                            id_valid_d = 1'b1;
                        end
                    end
                    ST_WAIT_IMM: begin
                        // The immediate is pure data; its IMM_BIT is not decoded.
                        id_instr_d    = hold_instr_q;
                        id_imm_d      = instruction_buf;
                        id_pc_d       = hold_pc_q;
                        id_two_word_d = 1'b1;
                        id_valid_d    = 1'b1;
                        state_d       = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            id_instr_q    <= NOP_WORD;
            id_imm_q      <= '0;
            id_pc_q       <= '0;
            id_valid_q    <= 1'b0;
            id_two_word_q <= 1'b0;
            hold_instr_q  <= '0;
            hold_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            id_instr_q    <= id_instr_d;
            id_imm_q      <= id_imm_d;
            id_pc_q       <= id_pc_d;
            id_valid_q    <= id_valid_d;
            id_two_word_q <= id_two_word_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
        end
    end

    assign id_instr    = id_instr_q;
    assign id_imm      = id_imm_q;
    assign id_pc       = id_pc_q;
    assign id_valid    = id_valid_q;
    assign id_two_word = id_two_word_q;

`ifdef IFID_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    // Counts every edge that registers id_valid=0, saturating at all-ones.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!id_valid_d && (bubble_cnt_q != 16'hFFFF))
            bubble_cnt_d = bubble_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bubble_cnt_q <= '0;
        else      bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_stage
// Description : Directed self-checking bench for if_id_stage (define
//               IFID_BUBBLE_CNT_EN to include the bubble counter test).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instruction_buf = '0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        stall = 1'b0;
    logic        jump_occured = 1'b0;
    logic        direct_jump = 1'b0;
    logic        fetch_hold;
    logic [15:0] id_instr;
    logic [15:0] id_imm;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        id_two_word;
`ifdef IFID_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    if_id_stage dut (
        .clk             (clk),
        .rst             (rst),
        .instruction_buf (instruction_buf),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .stall           (stall),
        .jump_occured    (jump_occured),
        .direct_jump     (direct_jump),
        .fetch_hold      (fetch_hold),
        .id_instr        (id_instr),
        .id_imm          (id_imm),
        .id_pc           (id_pc),
        .id_valid        (id_valid),
        .id_two_word     (id_two_word)
`ifdef IFID_BUBBLE_CNT_EN
        ,
        .bubble_cnt      (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [15:0] w, input logic [31:0] pc);
        instruction_buf = w;
        fetch_pc        = pc;
        fetch_valid     = 1'b1;
        step();
        fetch_valid     = 1'b0;
    endtask

    task automatic test_reset;
        feed(16'h1234, 32'd4);
        feed(16'h8001, 32'd8);
        #2 rst = 1'b0;
        #1;
        tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        tests_run++; if (id_instr !== 16'h0000) begin tests_failed++; $display("FAIL reset_instr: got %h want 0000", id_instr); end
        tests_run++; if (id_pc !== 32'd0) begin tests_failed++; $display("FAIL reset_pc: got %0d want 0", id_pc); end
`ifdef IFID_BUBBLE_CNT_EN
        tests_run++; if (bubble_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_bubble_cnt: got %0d want 0", bubble_cnt); end
`endif
        @(negedge clk) rst = 1'b1;
        step();
        tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_release_valid: got %b want 0", id_valid); end
        // Held opcode must be gone: next word issues as a one-word instruction.
        feed(16'h0042, 32'd20);
        tests_run++; if (id_instr !== 16'h0042 || id_valid !== 1'b1 || id_two_word !== 1'b0)
            begin tests_failed++; $display("FAIL reset_idle: got instr=%h v=%b tw=%b want 0042/1/0", id_instr, id_valid, id_two_word); end
    endtask

    task automatic test_one_word;
        feed(16'h1234, 32'd4);
        tests_run++; if (id_instr !== 16'h1234 || id_pc !== 32'd4 || id_valid !== 1'b1 || id_imm !== 16'h0000)
            begin tests_failed++; $display("FAIL one_word_a: got %h pc=%0d v=%b imm=%h want 1234 pc=4 v=1 imm=0000", id_instr, id_pc, id_valid, id_imm); end
        feed(16'h2345, 32'd5);
        tests_run++; if (id_instr !== 16'h2345 || id_pc !== 32'd5 || id_valid !== 1'b1 || id_imm !== 16'h0000)
            begin tests_failed++; $display("FAIL one_word_b: got %h pc=%0d v=%b imm=%h want 2345 pc=5 v=1 imm=0000", id_instr, id_pc, id_valid, id_imm); end
        step();
        tests_run++; if (id_valid !== 1'b0 || id_instr !== 16'h0000)
            begin tests_failed++; $display("FAIL idle_bubble: got v=%b instr=%h want 0/0000", id_valid, id_instr); end
    endtask

    task automatic test_two_word;
        feed(16'h8001, 32'd8);
        tests_run++; if (id_valid !== 1'b0 || id_instr !== 16'h0000)
            begin tests_failed++; $display("FAIL two_word_bubble: got v=%b instr=%h want 0/0000", id_valid, id_instr); end
        feed(16'hBEEF, 32'd9);
        tests_run++; if (id_instr !== 16'h8001 || id_imm !== 16'hBEEF || id_pc !== 32'd8 || id_two_word !== 1'b1 || id_valid !== 1'b1)
            begin tests_failed++; $display("FAIL two_word: got %h imm=%h pc=%0d tw=%b v=%b want 8001 BEEF 8 1 1", id_instr, id_imm, id_pc, id_two_word, id_valid); end
    endtask

    task automatic test_stall;
        feed(16'h8001, 32'd8);
        stall = 1'b1; instruction_buf = 16'hDEAD; fetch_pc = 32'd99; fetch_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++; if (fetch_hold !== 1'b1) begin tests_failed++; $display("FAIL stall_hold_%0d: got %b want 1", i, fetch_hold); end
            step();
            tests_run++; if (id_valid !== 1'b0 || id_instr !== 16'h0000)
                begin tests_failed++; $display("FAIL stall_frozen_%0d: got v=%b instr=%h want 0/0000", i, id_valid, id_instr); end
        end
        stall = 1'b0; fetch_valid = 1'b0;
        feed(16'hBEEF, 32'd9);
        tests_run++; if (id_instr !== 16'h8001 || id_imm !== 16'hBEEF || id_pc !== 32'd8 || id_two_word !== 1'b1 || id_valid !== 1'b1)
            begin tests_failed++; $display("FAIL stall_release: got %h imm=%h pc=%0d tw=%b v=%b want 8001 BEEF 8 1 1", id_instr, id_imm, id_pc, id_two_word, id_valid); end
        // A stall while a valid instruction is presented must keep it on the outputs.
        stall = 1'b1; instruction_buf = 16'h0011; fetch_valid = 1'b1;
        step();
        tests_run++; if (id_instr !== 16'h8001 || id_valid !== 1'b1 || id_imm !== 16'hBEEF)
            begin tests_failed++; $display("FAIL stall_valid_frozen: got %h v=%b imm=%h want 8001 1 BEEF", id_instr, id_valid, id_imm); end
        stall = 1'b0; fetch_valid = 1'b0;
    endtask

    task automatic test_flush;
        feed(16'h8001, 32'd8);
        stall = 1'b1; jump_occured = 1'b1; instruction_buf = 16'hBEEF; fetch_valid = 1'b1;
        #1;
        tests_run++; if (fetch_hold !== 1'b0) begin tests_failed++; $display("FAIL flush_hold: got %b want 0", fetch_hold); end
        step();
        tests_run++; if (id_valid !== 1'b0 || id_instr !== 16'h0000)
            begin tests_failed++; $display("FAIL flush_out: got v=%b instr=%h want 0/0000", id_valid, id_instr); end
        stall = 1'b0; jump_occured = 1'b0; fetch_valid = 1'b0;
        feed(16'h0042, 32'd12);
        tests_run++; if (id_instr !== 16'h0042 || id_pc !== 32'd12 || id_valid !== 1'b1 || id_two_word !== 1'b0 || id_imm !== 16'h0000)
            begin tests_failed++; $display("FAIL flush_next: got %h pc=%0d v=%b tw=%b imm=%h want 0042 12 1 0 0000", id_instr, id_pc, id_valid, id_two_word, id_imm); end
        feed(16'h8001, 32'd16);
        direct_jump = 1'b1; instruction_buf = 16'h1234; fetch_valid = 1'b1;
        step();
        tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL direct_jump_out: got v=%b want 0", id_valid); end
        direct_jump = 1'b0; fetch_valid = 1'b0;
        feed(16'h0055, 32'd18);
        tests_run++; if (id_instr !== 16'h0055 || id_pc !== 32'd18 || id_two_word !== 1'b0)
            begin tests_failed++; $display("FAIL direct_jump_next: got %h pc=%0d tw=%b want 0055 18 0", id_instr, id_pc, id_two_word); end
    endtask

`ifdef IFID_BUBBLE_CNT_EN
    task automatic test_bubble_cnt;
        @(negedge clk) rst = 1'b0;
        step();
        tests_run++; if (bubble_cnt !== 16'd0) begin tests_failed++; $display("FAIL bubble_cnt_reset: got %0d want 0", bubble_cnt); end
        @(negedge clk) rst = 1'b1;
        fetch_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        tests_run++; if (bubble_cnt !== 16'd5) begin tests_failed++; $display("FAIL bubble_cnt_5: got %0d want 5", bubble_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        step();
        test_reset();
        test_one_word();
        test_two_word();
        test_stall();
        test_flush();
`ifdef IFID_BUBBLE_CNT_EN
        test_bubble_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
